// File: rtl/param_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : param_memory_pkg
// Description : Shared FSM state encoding and engine mode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package param_memory_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_VERIFY = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic MODE_FILL   = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

endpackage : param_memory_pkg
`default_nettype wire

// File: rtl/param_memory_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-write, single-read storage with a registered,
//               read-before-write read port. Storage is never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Non-blocking read sees the pre-write word when addresses collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : mem_array
`default_nettype wire

// File: rtl/param_memory.sv
`default_nettype none
// ============================================================================
// Module      : param_memory
// Description : Memory with external access plus a fill/verify engine that
//               sweeps the whole array and counts verify mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] inputAddress,
    input  logic [DATA_WIDTH-1:0] inputValue,
    output logic [DATA_WIDTH-1:0] outputValue,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_WIDTH-1:0]  errorCount,
    output logic [ADDR_WIDTH-1:0] firstErrorAddress
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;
    localparam logic [ERR_WIDTH-1:0]  c_ERR_MAX   = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic                  r_cmp_valid;
    logic [DATA_WIDTH-1:0] r_pattern;
    logic                  r_done;
    logic [ERR_WIDTH-1:0]  r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_err;

    logic                  w_accept;
    logic                  w_done_nxt;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_mem_re;
    logic [ADDR_WIDTH-1:0] w_mem_raddr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  w_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_waddr = inputAddress;
        w_mem_wdata = inputValue;
        w_mem_re    = 1'b0;
        w_mem_raddr = inputAddress;
        case (r_state)
            S_IDLE: begin
                w_mem_we = memWrite;
                w_mem_re = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (mode == MODE_VERIFY) ? S_VERIFY : S_FILL;
                end
            end
            S_FILL: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_addr;
                w_mem_wdata = r_pattern;
                if (r_addr == c_LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_VERIFY: begin
                w_mem_re    = 1'b1;
                w_mem_raddr = r_addr;
                if (r_addr == c_LAST_ADDR) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Reset wins over any write, so an interrupted fill stops cleanly.
        if (reset) begin
            w_mem_we = 1'b0;
        end
    end

    assign w_mismatch = r_cmp_valid && (w_mem_rdata != r_pattern);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_cmp_addr  <= '0;
            r_cmp_valid <= 1'b0;
            r_pattern   <= '0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else begin
            r_done      <= w_done_nxt;
            r_cmp_valid <= (r_state == S_VERIFY);
            r_cmp_addr  <= r_addr;
            if (w_accept) begin
                r_pattern <= pattern;
                r_addr    <= '0;
                if (mode == MODE_VERIFY) begin
                    r_err_count <= '0;
                    r_first_err <= '0;
                end
            end else begin
                if (((r_state == S_FILL) || (r_state == S_VERIFY)) &&
                    (r_addr != c_LAST_ADDR)) begin
                    r_addr <= r_addr + 1'b1;
                end
                // A saturated count never returns to zero within a run.
                if (w_mismatch) begin
                    if (r_err_count != c_ERR_MAX) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                    if (r_err_count == '0) begin
                        r_first_err <= r_cmp_addr;
                    end
                end
            end
        end
    end

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata)
    );

    assign outputValue       = w_mem_rdata;
    assign busy              = (r_state != S_IDLE);
    assign done              = r_done;
    assign errorCount        = r_err_count;
    assign firstErrorAddress = r_first_err;

endmodule : param_memory
`default_nettype wire

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be at least 1.
REQ-002 Parameter ADDR_WIDTH, default 16: address width in bits; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter ERR_WIDTH, default 16: errorCount width in bits.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port memWrite, input, 1: external write enable.
REQ-007 Port inputAddress, input, ADDR_WIDTH: external read/write address.
REQ-008 Port inputValue, input, DATA_WIDTH: external write data.
REQ-009 Port outputValue, output, DATA_WIDTH: registered read data.
REQ-010 Port start, input, 1: single-cycle engine launch request.
REQ-011 Port mode, input, 1: engine operation sampled with start; 0 = FILL, 1 = VERIFY.
REQ-012 Port pattern, input, DATA_WIDTH: fill/compare word, sampled with start.
REQ-013 Port busy, output, 1: engine active.
REQ-014 Port done, output, 1: one-cycle pulse at engine completion.
REQ-015 Port errorCount, output, ERR_WIDTH: verify mismatch count.
REQ-016 Port firstErrorAddress, output, ADDR_WIDTH: address of the first verify mismatch.

Function
REQ-017 When idle and memWrite=1, the block SHALL write inputValue to inputAddress at the clock edge.
REQ-018 Reads SHALL take one cycle: outputValue after edge k SHALL equal the word at the inputAddress sampled at edge k, before any write at that edge (read-before-write).
REQ-019 The FSM SHALL have states IDLE, FILL, VERIFY and DRAIN.
REQ-020 In IDLE, start=1 SHALL latch mode and pattern, reset the internal address counter to 0 and go to FILL or VERIFY; when mode=1, start SHALL also clear errorCount and firstErrorAddress.
REQ-021 An external memWrite in the same cycle as an accepted start SHALL still be performed.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 In FILL, the block SHALL write pattern to addresses 0..DEPTH-1, one per cycle, over exactly DEPTH cycles, then return to IDLE with done=1 for one cycle.
REQ-024 In VERIFY, the block SHALL read addresses 0..DEPTH-1, one per cycle, and compare each returned word with pattern one cycle later.
REQ-025 After VERIFY issues the last address, the FSM SHALL enter DRAIN for one cycle to compare the last word, then return to IDLE with done=1; a verify therefore spans DEPTH+1 cycles.
REQ-026 On each mismatch, errorCount SHALL increment and saturate at 2**ERR_WIDTH-1.
REQ-027 On the first mismatch of a run only, firstErrorAddress SHALL capture that address.
REQ-028 While busy=1, the block SHALL ignore memWrite, inputAddress and start.
REQ-029 While busy=1, outputValue SHALL show the engine's read data in VERIFY and SHALL hold its value in FILL.
REQ-030 The address counter SHALL NOT wrap; terminal count is DEPTH-1.
REQ-031 errorCount and firstErrorAddress SHALL hold their values until the next verify start or reset.

Reset
REQ-032 On reset=1, at the next edge: FSM to IDLE; busy, done, outputValue, errorCount and firstErrorAddress to 0.
REQ-033 Reset SHALL NOT clear the storage array; reset during FILL SHALL leave the words already written intact, and no done pulse SHALL follow.
REQ-034 Reset SHALL take priority over start and memWrite in the same cycle.

Structure
REQ-035 Package param_memory_pkg SHALL hold the FSM state enum and the MODE_FILL=0 and MODE_VERIFY=1 constants.
REQ-036 Storage plus the registered read port SHALL be one sub-module, mem_array, with a single write port and a single read port; the FSM and counters SHALL live in param_memory.

Verification (DATA_WIDTH=16, ADDR_WIDTH=4, ERR_WIDTH=2 unless stated)
REQ-037 Write 0x1234 to address 3, then read address 3 -> outputValue=0x1234 one cycle later; address 4 unchanged.
REQ-038 FILL with pattern 0x5555 -> busy high for 16 cycles, one done pulse; then VERIFY with 0x5555 -> busy for 17 cycles, errorCount=0.
REQ-039 After the fill, external writes of 0xAAAA to addresses 7 and 9, then VERIFY with 0x5555 -> errorCount=2, firstErrorAddress=7.
REQ-040 Five corrupted addresses, then VERIFY -> errorCount saturates at 3; firstErrorAddress is the lowest corrupted address.
REQ-041 Reset asserted in the 6th FILL cycle -> busy=0 next edge, no done pulse; addresses 0..4 read 0x5555 and address 5 keeps its prior value.
REQ-042 start and memWrite of 0xBEEF to address 2 applied during busy -> both ignored; address 2 keeps the fill pattern and the run completes normally.
